// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: streams one 8-word block from main memory into the
// cache data array, then writes the tag on the final returned word.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int CNT_W           = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  output logic        fsm_busy,
  output logic        memory_read,
  output logic [15:0] memory_address,
  input  logic        memory_data_valid,
  output logic        write_data_array,
  output logic [15:0] fill_word_address,
  output logic        write_tag_array
);

  localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int BASE_W = 16 - OFF_W - 1;
  localparam logic [CNT_W-1:0] WORDS_CNT = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    recv_cnt_q, recv_cnt_d;

  // Byte/word offset bits of the miss address never select anything: fills start at word 0.
  logic unused_offset_bits;
  assign unused_offset_bits = ^miss_address[OFF_W:0];

  // Next-state and output decode; write strobes follow memory_data_valid with no added latency.
  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    issue_cnt_d       = issue_cnt_q;
    recv_cnt_d        = recv_cnt_q;
    fsm_busy          = 1'b0;
    memory_read       = 1'b0;
    memory_address    = 16'h0000;
    write_data_array  = 1'b0;
    fill_word_address = 16'h0000;
    write_tag_array   = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d     = FILL;
          base_d      = miss_address[15:OFF_W+1];
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        fsm_busy          = 1'b1;
        fill_word_address = {base_q, recv_cnt_q[OFF_W-1:0], 1'b0};
        if (issue_cnt_q < WORDS_CNT) begin
          memory_read    = 1'b1;
          memory_address = {base_q, issue_cnt_q[OFF_W-1:0], 1'b0};
          issue_cnt_d    = issue_cnt_q + ONE_CNT;
        end else begin
          memory_read = 1'b0;
        end
        // Issue and receive sides advance independently; only the receive side ends the fill.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          recv_cnt_d       = recv_cnt_q + ONE_CNT;
          if (recv_cnt_q == LAST_CNT) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, block base and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: per-cycle vector table plus a reactive
// latency-4 memory sequence with a bounded wait for the tag write.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic        write_data_array;
  logic [15:0] fill_word_address;
  logic        write_tag_array;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .CNT_W(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .write_data_array  (write_data_array),
    .fill_word_address (fill_word_address),
    .write_tag_array   (write_tag_array)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        miss;
    logic [15:0] miss_addr;
    logic        mdv;
    logic        busy;
    logic        rd;
    logic [15:0] maddr;
    logic        wda;
    logic [15:0] fwa;
    logic        tag;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic m, input logic [15:0] ma, input logic dv,
                     input logic busy, input logic rd, input logic [15:0] maddr,
                     input logic wda, input logic [15:0] fwa, input logic tag);
    vec_t v;
    v.rst_n = r; v.miss = m; v.miss_addr = ma; v.mdv = dv;
    v.busy = busy; v.rd = rd; v.maddr = maddr; v.wda = wda; v.fwa = fwa; v.tag = tag;
    tbl.push_back(v);
  endtask

  function automatic logic [15:0] wa(input logic [15:0] base, input int word);
    return base + 16'(2 * word);
  endfunction

  initial begin
    logic        busy, rd, dv;
    logic [15:0] ma;
    logic [3:0]  pipe;
    int          tags, busy_cyc, tag_cyc, done;
    logic [15:0] exp_fwa;

    rst_n = 1'b0; miss_detected = 1'b0; miss_address = 16'h0000; memory_data_valid = 1'b0;

    // Reset, then idle.
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    add(1'b0, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Miss at 0x1234, memory latency 4.
    add(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      busy = (k <= 12); rd = (k <= 8); dv = (k >= 5 && k <= 12);
      add(1'b1, 1'b0, 16'h0000, dv, busy, rd, rd ? wa(16'h1230, k - 1) : 16'h0000,
          dv, busy ? wa(16'h1230, (k >= 5) ? k - 5 : 0) : 16'h0000, k == 12);
    end

    // Miss at 0xFFFE, data returned in the same cycle as each request.
    add(1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      busy = (k <= 8);
      add(1'b1, 1'b0, 16'h0000, busy, busy, busy, busy ? wa(16'hFFF0, k - 1) : 16'h0000,
          busy, busy ? wa(16'hFFF0, k - 1) : 16'h0000, k == 8);
    end

    // Miss at 0x0108, data on alternating cycles 5,7,...,19.
    add(1'b1, 1'b1, 16'h0108, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      busy = (k <= 19); rd = (k <= 8); dv = (k >= 5 && k <= 19 && (k % 2) == 1);
      add(1'b1, 1'b0, 16'h0000, dv, busy, rd, rd ? wa(16'h0100, k - 1) : 16'h0000,
          dv, busy ? wa(16'h0100, (k >= 5) ? (k - 4) / 2 : 0) : 16'h0000, k == 19);
    end

    // Miss held high, address moves to 0x4000 mid-fill; second fill follows one IDLE cycle.
    add(1'b1, 1'b1, 16'h2000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      ma = (k < 3) ? 16'h2000 : 16'h4000;
      add(1'b1, 1'b1, ma, 1'b1, 1'b1, 1'b1, wa(16'h2000, k - 1), 1'b1, wa(16'h2000, k - 1), k == 8);
    end
    add(1'b1, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int k = 10; k <= 17; k++) begin
      add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, wa(16'h4000, k - 10), 1'b1, wa(16'h4000, k - 10), k == 17);
    end
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Reset mid-fill in cycle 6 while data is valid, then a fresh miss at 0x0020.
    add(1'b1, 1'b1, 16'h5550, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      add(1'b1, 1'b0, 16'h0000, k == 5, 1'b1, 1'b1, wa(16'h5550, k - 1), k == 5, 16'h5550, 1'b0);
    end
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    add(1'b1, 1'b1, 16'h0020, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int k = 9; k <= 16; k++) begin
      add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, wa(16'h0020, k - 9), 1'b1, wa(16'h0020, k - 9), k == 16);
    end

    // Stray data-valid pulses while idle.
    for (int k = 0; k < 3; k++) begin
      add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n = tbl[i].rst_n; miss_detected = tbl[i].miss;
      miss_address = tbl[i].miss_addr; memory_data_valid = tbl[i].mdv;
      #4;
      chk("fsm_busy", i, {15'b0, fsm_busy}, {15'b0, tbl[i].busy});
      chk("memory_read", i, {15'b0, memory_read}, {15'b0, tbl[i].rd});
      chk("memory_address", i, memory_address, tbl[i].maddr);
      chk("write_data_array", i, {15'b0, write_data_array}, {15'b0, tbl[i].wda});
      chk("fill_word_address", i, fill_word_address, tbl[i].fwa);
      chk("write_tag_array", i, {15'b0, write_tag_array}, {15'b0, tbl[i].tag});
    end

    // Reactive latency-4 memory on a miss at 0x0A0C, bounded wait for completion.
    pipe = 4'b0000; tags = 0; busy_cyc = 0; tag_cyc = -1; done = 0; exp_fwa = 16'h0A00;
    for (int cyc = 0; cyc < 60 && done == 0; cyc++) begin
      @(posedge clk);
      #1;
      miss_detected = (cyc == 0); miss_address = 16'h0A0C; memory_data_valid = pipe[3];
      #4;
      if (fsm_busy) busy_cyc++;
      if (write_tag_array) begin
        tags++;
        tag_cyc = cyc;
      end
      if (write_data_array) begin
        chk("hs_fill_addr", cyc, fill_word_address, exp_fwa);
        exp_fwa = exp_fwa + 16'h0002;
      end
      pipe = {pipe[2:0], memory_read};
      if (cyc > 0 && !fsm_busy && tags > 0) done = 1;
    end
    memory_data_valid = 1'b0; miss_detected = 1'b0;
    chk("hs_done", 0, 16'(done), 16'd1);
    chk("hs_tag_count", 0, 16'(tags), 16'd1);
    chk("hs_tag_cycle", 0, 16'(tag_cyc), 16'd12);
    chk("hs_busy_cycles", 0, 16'(busy_cyc), 16'd12);
    chk("hs_words", 0, exp_fwa, 16'h0A10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
